array_loader: RTL and testbench

ARRAY_LOADER -- requirements
Module: array_loader

---
 rtl/array_loader_pkg.sv | 27 ++
 rtl/array_loader_ctrl.sv | 84 ++++++++
 rtl/array_loader.sv | 90 +++++++++
 tb/tb_array_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/array_loader_pkg.sv
// ============================================================================
// array_loader_pkg : shared widths and state type for the frame loader
// Rev 1.0
// ============================================================================
`default_nettype none

package array_loader_pkg;

  localparam int WORD_W  = 32;
  localparam int WORDS   = 16;
  localparam int FRAME_W = 512;
  localparam int CNT_W   = $clog2(WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } ldr_state_t;

  // In_par is chosen so that the word plus its parity bit has even weight.
  function automatic logic even_par_ok(input logic [WORD_W-1:0] data, input logic par);
    return (^data) == par;
  endfunction

endpackage

`default_nettype wire

// File: rtl/array_loader_ctrl.sv
// ============================================================================
// array_loader_ctrl : IDLE/FILL/HOLD sequencer and word counter for the loader
// Rev 1.0
// ============================================================================
`default_nettype none

module array_loader_ctrl
  import array_loader_pkg::*;
(
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             In_valid,
  input  logic             Flush,
  input  logic             Out_ready,
  output logic             In_ready,
  output logic             Out_valid,
  output logic             beat_o,
  output logic             first_beat_o,
  output logic [CNT_W-1:0] word_idx_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  ldr_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             beat;

  // Ready is a pure state decode so Out_ready never reaches In_ready.
  assign In_ready     = Resetn & (state_q != ST_HOLD);
  assign Out_valid    = (state_q == ST_HOLD);
  assign beat         = In_valid & In_ready & ~Flush;
  assign beat_o       = beat;
  assign first_beat_o = beat & (state_q == ST_IDLE);
  assign word_idx_o   = count_q;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (Flush) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (beat) begin
            state_d = ST_FILL;
            count_d = CNT_W'(1);
          end
        end
        ST_FILL: begin
          if (beat) begin
            // The counter wraps to zero on the last word, ready for the next frame.
            count_d = count_q + 1'b1;
            if (count_q == LAST_IDX) begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (Out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/array_loader.sv
// ============================================================================
// array_loader : packs 16 x 32-bit beats into a 512-bit frame for the mux bank
// Optional parity checking is built when ARRAY_LOADER_PARITY_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

module array_loader
  import array_loader_pkg::*;
(
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               In_valid,
  output logic               In_ready,
  input  logic [WORD_W-1:0]  In_data,
  input  logic               In_sel,
  input  logic               Flush,
  output logic [FRAME_W-1:0] Out_Input,
  output logic               Out_Sel,
  output logic               Out_valid,
  input  logic               Out_ready
`ifdef ARRAY_LOADER_PARITY_EN
  ,
  input  logic               In_par,
  output logic               Par_err
`endif
);

  logic             beat;
  logic             first_beat;
  logic [CNT_W-1:0] word_idx;
  logic             sel_q;

  array_loader_ctrl u_ctrl (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .In_valid     (In_valid),
    .Flush        (Flush),
    .Out_ready    (Out_ready),
    .In_ready     (In_ready),
    .Out_valid    (Out_valid),
    .beat_o       (beat),
    .first_beat_o (first_beat),
    .word_idx_o   (word_idx)
  );

  // Words are only ever overwritten by a new beat, never cleared between frames.
  generate
    for (genvar w = 0; w < WORDS; w++) begin : g_word
      localparam logic [CNT_W-1:0] IDX = CNT_W'(w);
      logic [WORD_W-1:0] word_q;

      always_ff @(posedge Clock) begin
        if (!Resetn) begin
          word_q <= '0;
        end else if (beat && (word_idx == IDX)) begin
          word_q <= In_data;
        end
      end

      assign Out_Input[w*WORD_W +: WORD_W] = word_q;
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      sel_q <= 1'b0;
    end else if (first_beat) begin
      sel_q <= In_sel;
    end
  end

  assign Out_Sel = sel_q;

`ifdef ARRAY_LOADER_PARITY_EN
  logic par_err_q;

  always_ff @(posedge Clock) begin
    if (!Resetn || Flush) begin
      par_err_q <= 1'b0;
    end else if (beat && !even_par_ok(In_data, In_par)) begin
      par_err_q <= 1'b1;
    end
  end

  assign Par_err = par_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_array_loader.sv
// ============================================================================
// tb_array_loader : directed + randomized bench with a frame-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_array_loader;

  logic         Clock = 1'b0;
  logic         Resetn = 1'b0;
  logic         In_valid = 1'b0;
  logic         In_ready;
  logic [31:0]  In_data = '0;
  logic         In_sel = 1'b0;
  logic         Flush = 1'b0;
  logic [511:0] Out_Input;
  logic         Out_Sel;
  logic         Out_valid;
  logic         Out_ready = 1'b0;
  logic         In_par = 1'b0;
`ifdef ARRAY_LOADER_PARITY_EN
  logic         Par_err;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: the words collected so far and whether a full frame is held.
  logic [31:0] m_words [16];
  logic        m_sel  = 1'b0;
  logic        m_hold = 1'b0;
  int          m_n    = 0;
  logic        m_perr = 1'b0;

  array_loader dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .In_data   (In_data),
    .In_sel    (In_sel),
    .Flush     (Flush),
    .Out_Input (Out_Input),
    .Out_Sel   (Out_Sel),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready)
`ifdef ARRAY_LOADER_PARITY_EN
    ,
    .In_par    (In_par),
    .Par_err   (Par_err)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] model_frame();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = m_words[i];
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) m_words[i] = '0;
    forever begin
      @(posedge Clock);
      if (!Resetn) begin
        for (int i = 0; i < 16; i++) m_words[i] = '0;
        m_sel = 1'b0; m_hold = 1'b0; m_n = 0; m_perr = 1'b0;
      end else if (Flush) begin
        m_n = 0; m_hold = 1'b0; m_perr = 1'b0;
      end else if (m_hold) begin
        if (Out_ready) m_hold = 1'b0;
      end else if (In_valid) begin
        if (In_par != ^In_data) m_perr = 1'b1;
        m_words[m_n] = In_data;
        if (m_n == 0) m_sel = In_sel;
        m_n++;
        if (m_n == 16) begin
          m_hold = 1'b1;
          m_n = 0;
        end
      end
      #1;
      chk("in_ready",  {511'd0, In_ready},  {511'd0, (Resetn && !m_hold)});
      chk("out_valid", {511'd0, Out_valid}, {511'd0, m_hold});
      chk("out_sel",   {511'd0, Out_Sel},   {511'd0, m_sel});
      chk("out_input", Out_Input, model_frame());
`ifdef ARRAY_LOADER_PARITY_EN
      chk("par_err",   {511'd0, Par_err},   {511'd0, m_perr});
`endif
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic f,
                       input logic ordy, input logic rn, input logic bad_par);
    @(negedge Clock);
    In_valid  = v;
    In_data   = d;
    In_sel    = s;
    Flush     = f;
    Out_ready = ordy;
    Resetn    = rn;
    In_par    = bad_par ? ~(^d) : ^d;
  endtask

  task automatic settle();
    @(posedge Clock);
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset behaviour
    repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("rst_ready", {511'd0, In_ready}, 512'd0);
    chk("rst_valid", {511'd0, Out_valid}, 512'd0);
    chk("rst_frame", Out_Input, 512'd0);
    idle();
    settle();
    chk("release_ready", {511'd0, In_ready}, 512'd1);

    // Back-to-back frame, In_sel only honoured on beat 0
    for (int k = 0; k < 16; k++) drive(1'b1, 32'hA0 + k, (k == 0), 1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("a_valid", {511'd0, Out_valid}, 512'd1);
    chk("a_word0", {480'd0, Out_Input[31:0]}, 512'hA0);
    chk("a_word15", {480'd0, Out_Input[511:480]}, 512'hAF);
    chk("a_sel", {511'd0, Out_Sel}, 512'd1);

    // Hold under backpressure with upstream still offering data
    for (int k = 0; k < 5; k++) drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("hold_ready", {511'd0, In_ready}, 512'd0);
    chk("hold_word0", {480'd0, Out_Input[31:0]}, 512'hA0);
    drive(1'b1, 32'h5555, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    settle();
    chk("consume_valid", {511'd0, Out_valid}, 512'd0);
    chk("consume_ready", {511'd0, In_ready}, 512'd1);

    // Partial frame discarded by Flush, then a complete new frame
    for (int k = 0; k < 7; k++) drive(1'b1, 32'hB0 + k, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) drive(1'b1, 32'hC0 + k, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("c_valid", {511'd0, Out_valid}, 512'd1);
    chk("c_word0", {480'd0, Out_Input[31:0]}, 512'hC0);
    chk("c_word7", {480'd0, Out_Input[255:224]}, 512'hC7);
    chk("c_sel", {511'd0, Out_Sel}, 512'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Flush beats a simultaneous beat
    drive(1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    settle();
    chk("fl_word0", {480'd0, Out_Input[31:0]}, 512'hC0);
    chk("fl_valid", {511'd0, Out_valid}, 512'd0);
    drive(1'b1, 32'hE0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("e_word0", {480'd0, Out_Input[31:0]}, 512'hE0);
    chk("e_sel", {511'd0, Out_Sel}, 512'd1);

    // Reset while holding a frame
    for (int k = 1; k < 16; k++) drive(1'b1, 32'hE0 + k, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("e_valid", {511'd0, Out_valid}, 512'd1);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("hrst_valid", {511'd0, Out_valid}, 512'd0);
    chk("hrst_frame", Out_Input, 512'd0);
    chk("hrst_sel", {511'd0, Out_Sel}, 512'd0);
    chk("hrst_ready", {511'd0, In_ready}, 512'd0);
    idle();

`ifdef ARRAY_LOADER_PARITY_EN
    // Bad parity on beat 3 is sticky until Flush
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b1, (k == 3));
      if (k == 2 || k == 3) begin
        settle();
        chk("par_beat", {511'd0, Par_err}, {511'd0, (k == 3)});
      end
    end
    settle();
    chk("par_sticky", {511'd0, Par_err}, 512'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    settle();
    chk("par_flush", {511'd0, Par_err}, 512'd0);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      drive(($urandom_range(0, 9) < 7), $urandom, $urandom_range(0, 1),
            ($urandom_range(0, 31) == 0), $urandom_range(0, 1),
            ($urandom_range(0, 127) != 0), ($urandom_range(0, 15) == 0));
    end
    idle();
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
